keyed_cell_array: RTL and testbench

- Parametrised, clocked successor to the single key-programmable 2-input gate used for logic locking.
- Holds NUM_CELLS independent cells. Each cell computes NAND, NOR or XOR of its two inputs, chosen by a 2-bit key slice.
- The key is shifted in serially and committed under a small FSM. Data is processed only while a committed key is active.
- Results leave through a LATENCY-deep valid-qualified pipeline. The block drops into locked netlists wherever multiple keyed gates share one key port.

---
 rtl/keyed_cell_array.sv | 126 ++++++++++++
 tb/tb_keyed_cell_array.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyed_cell_array.sv
// Array of key-programmable NAND/NOR/XOR cells sharing one serially loaded key,
// with results leaving through a LATENCY-deep valid-qualified pipeline.
//
// state  | meaning
// LOCKED | no key loaded; data dropped; key bits accepted from index 0
// LOAD   | key partially or fully shifted in; waiting for commit
// ACTIVE | committed key in use; inputs flow through the pipeline
module keyed_cell_array #(
  parameter int NUM_CELLS = 8,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_bit,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 key_commit,
  input  logic                 key_clear,
  output logic                 key_locked,
  output logic                 load_err,
  input  logic                 in_valid,
  input  logic [NUM_CELLS-1:0] in_a,
  input  logic [NUM_CELLS-1:0] in_b,
  output logic                 out_valid,
  output logic [NUM_CELLS-1:0] out_y
);

  localparam int KEY_W = 2 * NUM_CELLS;
  localparam int CW    = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] KEY_FULL = CW'(KEY_W);

  typedef enum logic [1:0] {LOCKED, LOAD, ACTIVE} state_t;

  state_t               state;
  logic [KEY_W-1:0]     key_reg;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 accept;
  logic [NUM_CELLS-1:0] cell_y;
  logic                 vld [LATENCY];
  logic [NUM_CELLS-1:0] dat [LATENCY];

  // key_ready is the only output decoded combinationally, from state and count.
  assign key_ready = (state == LOCKED) || ((state == LOAD) && (cnt < KEY_FULL));
  assign accept    = key_valid & key_ready;
  assign cnt_nxt   = cnt + CW'(accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOCKED;
      key_reg    <= '0;
      cnt        <= '0;
      key_locked <= 1'b1;
      load_err   <= 1'b0;
    end else if (key_clear) begin
      state      <= LOCKED;
      key_reg    <= '0;
      cnt        <= '0;
      key_locked <= 1'b1;
    end else begin
      case (state)
        LOCKED, LOAD: begin
          if (accept) begin
            for (int k = 0; k < KEY_W; k++)
              if (cnt == CW'(k)) key_reg[k] <= key_bit;
            cnt <= cnt_nxt;
          end
          // A bit accepted alongside the commit counts toward a full key.
          if (key_commit) begin
            if (cnt_nxt == KEY_FULL) begin
              state      <= ACTIVE;
              key_locked <= 1'b0;
            end else begin
              load_err   <= 1'b1;
              key_reg    <= '0;
              cnt        <= '0;
              state      <= LOCKED;
              key_locked <= 1'b1;
            end
          end else if (accept) begin
            state <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cell_y = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (key_reg[2*i])
        cell_y[i] = in_a[i] ^ in_b[i];
      else if (key_reg[2*i+1])
        cell_y[i] = ~(in_a[i] | in_b[i]);
      else
        cell_y[i] = ~(in_a[i] & in_b[i]);
    end
  end

  // Data is zeroed whenever not valid so ungated cell outputs never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        vld[s] <= 1'b0;
        dat[s] <= '0;
      end
    end else if (key_clear) begin
      for (int s = 0; s < LATENCY; s++) begin
        vld[s] <= 1'b0;
        dat[s] <= '0;
      end
    end else begin
      vld[0] <= in_valid && (state == ACTIVE);
      dat[0] <= (in_valid && (state == ACTIVE)) ? cell_y : '0;
      for (int s = 1; s < LATENCY; s++) begin
        vld[s] <= vld[s-1];
        dat[s] <= dat[s-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_y     = dat[LATENCY-1];

endmodule

// File: tb/tb_keyed_cell_array.sv
// Directed bench for keyed_cell_array: one LATENCY=1 and one LATENCY=3 instance
// driven by the same stimulus.
module tb_keyed_cell_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_bit, key_valid, key_commit, key_clear, in_valid;
  logic [7:0] in_a, in_b;

  logic       key_ready_1, key_locked_1, load_err_1, out_valid_1;
  logic [7:0] out_y_1;
  logic       key_ready_3, key_locked_3, load_err_3, out_valid_3;
  logic [7:0] out_y_3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keyed_cell_array #(.NUM_CELLS(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
    .key_ready(key_ready_1), .key_commit(key_commit), .key_clear(key_clear),
    .key_locked(key_locked_1), .load_err(load_err_1), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_1), .out_y(out_y_1)
  );

  keyed_cell_array #(.NUM_CELLS(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
    .key_ready(key_ready_3), .key_commit(key_commit), .key_clear(key_clear),
    .key_locked(key_locked_3), .load_err(load_err_3), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_3), .out_y(out_y_3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_key(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      step();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    step();
    key_commit = 1'b0;
  endtask

  task automatic clear();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
  endtask

  task automatic load_key(input logic [15:0] k);
    clear();
    shift_key(k, 16);
    commit();
  endtask

  // {key_locked, key_ready, load_err, out_valid, out_y}
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1} !== {4'b1100, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_l1: got %b %b %b %b %h want 1 1 0 0 00",
               key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1);
    end
    vectors++;
    if ({key_locked_3, key_ready_3, load_err_3, out_valid_3, out_y_3} !== {4'b1100, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_l3: got %b %b %b %b %h want 1 1 0 0 00",
               key_locked_3, key_ready_3, load_err_3, out_valid_3, out_y_3);
    end
    rst = 1'b0;
    step();
  endtask

  // in_a=F0, in_b=CC. 8888: odd cells NOR, even cells NAND -> 0x17.
  task automatic test_cell_functions();
    logic [15:0] keys [3];
    logic [7:0]  exp  [3];
    keys = '{16'h0000, 16'h5555, 16'h8888};
    exp  = '{8'h3F, 8'h3C, 8'h17};
    for (int t = 0; t < 3; t++) begin
      load_key(keys[t]);
      vectors++;
      if ({key_locked_1, key_ready_1, key_locked_3, key_ready_3} !== 4'b0000) begin
        miscompares++;
        $display("FAIL active_flags key=%h: got %b%b%b%b want 0000", keys[t],
                 key_locked_1, key_ready_1, key_locked_3, key_ready_3);
      end
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC;
      step();
      in_valid = 1'b0;
      vectors++;
      if ({out_valid_1, out_y_1} !== {1'b1, exp[t]}) begin
        miscompares++;
        $display("FAIL cell_l1 key=%h: got v=%b y=%h want v=1 y=%h", keys[t], out_valid_1, out_y_1, exp[t]);
      end
      step();
      vectors++;
      if (out_valid_1 !== 1'b0 || out_valid_3 !== 1'b0) begin
        miscompares++;
        $display("FAIL cell_early key=%h: got v1=%b v3=%b want 0 0", keys[t], out_valid_1, out_valid_3);
      end
      step();
      vectors++;
      if ({out_valid_3, out_y_3} !== {1'b1, exp[t]}) begin
        miscompares++;
        $display("FAIL cell_l3 key=%h: got v=%b y=%h want v=1 y=%h", keys[t], out_valid_3, out_y_3, exp[t]);
      end
    end
  endtask

  task automatic test_short_key();
    clear();
    shift_key(16'h5555, 15);
    vectors++;
    if ({key_locked_1, key_ready_1} !== 2'b11) begin
      miscompares++;
      $display("FAIL short_pre: got locked=%b ready=%b want 1 1", key_locked_1, key_ready_1);
    end
    commit();
    vectors++;
    if ({load_err_1, key_locked_1, key_ready_1, load_err_3, key_locked_3} !== 5'b11111) begin
      miscompares++;
      $display("FAIL short_commit: got err=%b locked=%b ready=%b err3=%b locked3=%b want 1 1 1 1 1",
               load_err_1, key_locked_1, key_ready_1, load_err_3, key_locked_3);
    end
    in_a = 8'hF0; in_b = 8'hCC;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      step();
      vectors++;
      if ({out_valid_1, out_y_1, out_valid_3, out_y_3} !== 18'h0) begin
        miscompares++;
        $display("FAIL short_gate c=%0d: got v1=%b y1=%h v3=%b y3=%h want 0 00 0 00",
                 c, out_valid_1, out_y_1, out_valid_3, out_y_3);
      end
    end
    in_valid = 1'b0;
    shift_key(16'h5555, 16);
    commit();
    vectors++;
    if ({load_err_1, key_locked_1} !== 2'b10) begin
      miscompares++;
      $display("FAIL reload: got err=%b locked=%b want 1 0", load_err_1, key_locked_1);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid_1, out_y_1} !== {1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL reload_data: got v=%b y=%h want v=1 y=3c", out_valid_1, out_y_1);
    end
    step(); step();
  endtask

  task automatic test_same_cycle_commit();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    shift_key(16'h0000, 15);
    key_valid = 1'b1; key_bit = 1'b0; key_commit = 1'b1;
    step();
    key_valid = 1'b0; key_commit = 1'b0;
    vectors++;
    if ({key_locked_1, load_err_1, key_locked_3, load_err_3} !== 4'b0000) begin
      miscompares++;
      $display("FAIL same_cycle: got locked=%b err=%b locked3=%b err3=%b want 0 0 0 0",
               key_locked_1, load_err_1, key_locked_3, load_err_3);
    end
    clear();
    shift_key(16'h5555, 16);
    vectors++;
    if ({key_ready_1, key_locked_1} !== 2'b01) begin
      miscompares++;
      $display("FAIL full_ready: got ready=%b locked=%b want 0 1", key_ready_1, key_locked_1);
    end
    key_valid = 1'b1; key_bit = 1'b1;
    step();
    key_valid = 1'b0; key_bit = 1'b0;
    vectors++;
    if ({key_ready_1, key_locked_1, load_err_1} !== 3'b010) begin
      miscompares++;
      $display("FAIL extra_bit: got ready=%b locked=%b err=%b want 0 1 0", key_ready_1, key_locked_1, load_err_1);
    end
    commit();
    vectors++;
    if ({key_locked_1, load_err_1} !== 2'b00) begin
      miscompares++;
      $display("FAIL extra_commit: got locked=%b err=%b want 0 0", key_locked_1, load_err_1);
    end
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid_1, out_y_1} !== {1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL extra_data: got v=%b y=%h want v=1 y=3c", out_valid_1, out_y_1);
    end
    step(); step();
  endtask

  // Key 0x5555 (all XOR) is active on entry.
  task automatic test_back_to_back();
    logic [7:0] va  [5];
    logic [7:0] vb  [5];
    logic [7:0] exp [5];
    va  = '{8'h01, 8'hA5, 8'hFF, 8'h3C, 8'h80};
    vb  = '{8'h10, 8'h5A, 8'h0F, 8'h3C, 8'h81};
    exp = '{8'h11, 8'hFF, 8'hF0, 8'h00, 8'h01};
    for (int c = 1; c <= 9; c++) begin
      if (c <= 5) begin
        in_valid = 1'b1; in_a = va[c-1]; in_b = vb[c-1];
      end else begin
        in_valid = 1'b0;
      end
      step();
      vectors++;
      if (out_valid_3 !== (c >= 3 && c <= 7)) begin
        miscompares++;
        $display("FAIL b2b_valid3 c=%0d: got %b want %b", c, out_valid_3, (c >= 3 && c <= 7));
      end
      if (c >= 3 && c <= 7) begin
        vectors++;
        if (out_y_3 !== exp[c-3]) begin
          miscompares++;
          $display("FAIL b2b_data3 c=%0d: got %h want %h", c, out_y_3, exp[c-3]);
        end
      end
      vectors++;
      if (out_valid_1 !== (c <= 5) || (c <= 5 && out_y_1 !== exp[c-1])) begin
        miscompares++;
        $display("FAIL b2b_l1 c=%0d: got v=%b y=%h want v=%b y=%h", c, out_valid_1, out_y_1,
                 (c <= 5), (c <= 5) ? exp[c-1] : 8'h00);
      end
    end
  endtask

  task automatic test_clear_inflight();
    in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    vectors++;
    if ({out_valid_3, key_locked_3, out_y_3} !== {2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL clear_now: got v=%b locked=%b y=%h want 0 1 00", out_valid_3, key_locked_3, out_y_3);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if ({out_valid_1, out_valid_3, out_y_3} !== 10'h0) begin
        miscompares++;
        $display("FAIL clear_after c=%0d: got v1=%b v3=%b y3=%h want 0 0 00", c, out_valid_1, out_valid_3, out_y_3);
      end
    end
  endtask

  task automatic test_async_reset();
    clear();
    commit();
    vectors++;
    if ({load_err_1, key_locked_1} !== 2'b11) begin
      miscompares++;
      $display("FAIL locked_commit: got err=%b locked=%b want 1 1", load_err_1, key_locked_1);
    end
    shift_key(16'hFFFF, 5);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1} !== {4'b1100, 8'h00}) begin
      miscompares++;
      $display("FAIL async_load: got %b %b %b %b %h want 1 1 0 0 00",
               key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1);
    end
    #2;
    rst = 1'b0;
    step();
    load_key(16'h5555);
    in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
    step(); step();
    vectors++;
    if ({out_valid_1, out_y_1, key_locked_1} !== {1'b1, 8'h3C, 1'b0}) begin
      miscompares++;
      $display("FAIL pre_async: got v=%b y=%h locked=%b want 1 3c 0", out_valid_1, out_y_1, key_locked_1);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1,
         key_locked_3, key_ready_3, out_valid_3, out_y_3} !== {4'b1100, 8'h00, 3'b110, 8'h00}) begin
      miscompares++;
      $display("FAIL async_active: got l1=%b r1=%b e1=%b v1=%b y1=%h l3=%b r3=%b v3=%b y3=%h",
               key_locked_1, key_ready_1, load_err_1, out_valid_1, out_y_1,
               key_locked_3, key_ready_3, out_valid_3, out_y_3);
    end
    #2;
    rst = 1'b0;
    step(); step();
    in_valid = 1'b0;
    vectors++;
    if ({out_valid_1, out_valid_3, key_locked_1} !== 3'b001) begin
      miscompares++;
      $display("FAIL post_async: got v1=%b v3=%b locked=%b want 0 0 1", out_valid_1, out_valid_3, key_locked_1);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_bit = 1'b0; key_valid = 1'b0; key_commit = 1'b0; key_clear = 1'b0;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    test_reset();
    test_cell_functions();
    test_short_key();
    test_same_cycle_commit();
    load_key(16'h5555);
    test_back_to_back();
    load_key(16'h5555);
    test_clear_inflight();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
